// File: rtl/klp32_dmem_responder.sv
// KLP32 data-memory responder: RV32I loads/stores behind valid/ready request and response
// channels, with a programmable response latency and access-error reporting.
module klp32_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          f3_legal, misaligned, out_of_range, we_bad, req_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, rd_shift, load_data, wr_data;
    logic [15:0]   rd_half;
    logic [3:0]    wr_be;
    logic          accept;

    assign word_idx = req_addr_i[AW+1:2];
    assign rd_word  = mem_q[word_idx];
    assign accept   = req_valid_i & req_ready_o;

    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b100: f3_legal = 1'b1;
            3'b001, 3'b101: begin
                f3_legal   = 1'b1;
                misaligned = req_addr_i[0];
            end
            3'b010: begin
                f3_legal   = 1'b1;
                misaligned = |req_addr_i[1:0];
            end
            default: f3_legal = 1'b0;
        endcase
        // addr >= 4*DEPTH_WORDS is equivalent to the word index reaching DEPTH_WORDS
        out_of_range = req_addr_i[31:2] >= 30'(DEPTH_WORDS);
        we_bad       = req_we_i & req_funct3_i[2];
        req_err      = ~f3_legal | misaligned | out_of_range | we_bad;
    end

    // Lane selection and extension of the addressed byte/halfword
    always_comb begin
        rd_shift = rd_word >> {req_addr_i[1:0], 3'b000};
        rd_half  = req_addr_i[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_funct3_i)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_data = {24'b0, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'b0, rd_half};
            3'b010:  load_data = rd_word;
            default: load_data = 32'b0;
        endcase
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata_i;
        case (req_funct3_i)
            3'b000: begin
                wr_be   = 4'b0001 << req_addr_i[1:0];
                wr_data = {4{req_wdata_i[7:0]}};
            end
            3'b001: begin
                wr_be   = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata_i[15:0]}};
            end
            3'b010:  wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // Memory is deliberately not reset; stores commit at the acceptance edge
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept && req_we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    cnt_d   = LoadCnt;
                    state_d = (LATENCY <= 1) ? StResp : StWait;
                    err_d   = req_err;
                    rdata_d = (req_err || req_we_i) ? 32'b0 : load_data;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = StIdle;
                    rdata_d = 32'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_klp32_dmem_responder.sv
// Bench for klp32_dmem_responder: two instances (latency 1 and 3) checked against a byte-array
// reference model, a directed vector table and hand-written backpressure/reset sequences.
module tb_klp32_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mdl [2][1024];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl [$];

    klp32_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_err_o(rsp_err[0])
    );

    klp32_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_err_o(rsp_err[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
        logic legal, mis;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        mis   = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
        return !legal || mis || (we && (f3 == 3'd4 || f3 == 3'd5)) || (addr >= 32'd1024);
    endfunction

    function automatic logic [31:0] model_load(input int w, input logic [2:0] f3,
                                               input logic [31:0] addr);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        a = int'(addr[9:0]);
        b = mdl[w][a];
        h = {mdl[w][(a + 1) % 1024], mdl[w][a]};
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return {24'b0, b};
            3'd1:    return 32'($signed(h));
            3'd5:    return {16'b0, h};
            default: return {mdl[w][a + 3], mdl[w][a + 2], mdl[w][a + 1], mdl[w][a]};
        endcase
    endfunction

    task automatic model_store(input int w, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data);
        int nbytes;
        nbytes = 1 << f3[1:0];
        for (int i = 0; i < nbytes; i++) begin
            mdl[w][int'(addr[9:0]) + i] = data[8*i +: 8];
        end
    endtask

    // One full transaction; holds rsp_ready low for 'hold' cycles once the response shows up
    task automatic txn(input int w, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       input string name, output logic [31:0] got_d, output logic got_e);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        int          lat;
        lat   = (w == 0) ? 1 : 3;
        exp_e = model_err(we, f3, addr);
        exp_d = (exp_e || we) ? 32'd0 : model_load(w, f3, addr);
        @(negedge clk);
        req_valid[w]  = 1'b1;
        req_we[w]     = we;
        req_funct3[w] = f3;
        req_addr[w]   = addr;
        req_wdata[w]  = wdata;
        chk({name, ".req_ready_idle"}, 32'(req_ready[w]), 32'd1);
        @(posedge clk);
        if (we && !exp_e) model_store(w, f3, addr, wdata);
        #1;
        req_valid[w]  = 1'b0;
        req_we[w]     = 1'($urandom);
        req_funct3[w] = 3'($urandom);
        req_addr[w]   = $urandom;
        req_wdata[w]  = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[w] && n < 40);
        chk({name, ".latency"}, 32'(n), 32'(lat));
        got_d = rsp_rdata[w];
        got_e = rsp_err[w];
        chk({name, ".rdata"}, rsp_rdata[w], exp_d);
        chk({name, ".err"}, 32'(rsp_err[w]), 32'(exp_e));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({name, ".hold_valid"}, 32'(rsp_valid[w]), 32'd1);
            chk({name, ".hold_rdata"}, rsp_rdata[w], exp_d);
            chk({name, ".hold_err"}, 32'(rsp_err[w]), 32'(exp_e));
            chk({name, ".hold_req_ready"}, 32'(req_ready[w]), 32'd0);
        end
        rsp_ready[w] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[w] = 1'b0;
        chk({name, ".done_valid"}, 32'(rsp_valid[w]), 32'd0);
        chk({name, ".done_req_ready"}, 32'(req_ready[w]), 32'd1);
    endtask

    initial begin
        logic [31:0] gd, saved;
        logic        ge;
        logic [2:0]  f3s [10];
        int          w;
        logic [31:0] a;

        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_funct3[i] = 3'd0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            rsp_ready[i]  = 1'b0;
        end
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset.req_ready", 32'(req_ready[i]), 32'd1);
            chk("reset.rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("reset.rsp_err", 32'(rsp_err[i]), 32'd0);
            chk("reset.rsp_rdata", rsp_rdata[i], 32'd0);
        end

        // Give every word the random phase may load a known value
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 18; k++) begin
                a = (k < 16) ? 32'(4 * k) : 32'(1016 + 4 * (k - 16));
                txn(i, 1'b1, 3'd2, a, $urandom, 0, "init", gd, ge);
            end
        end

        tbl.push_back('{1'b1, 3'd2, 32'd8,    32'd2,          32'd0,          1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'd8,    32'd0,          32'h00000002,   1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'd8,    32'h11223344,   32'd0,          1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'd9,    32'h000000F2,   32'd0,          1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'd9,    32'd0,          32'hFFFFFFF2,   1'b0});
        tbl.push_back('{1'b0, 3'd4, 32'd9,    32'd0,          32'h000000F2,   1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'd8,    32'd0,          32'h1122F244,   1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'd40,   32'hCAFE0000,   32'd0,          1'b0});
        tbl.push_back('{1'b1, 3'd1, 32'd40,   32'h00008002,   32'd0,          1'b0});
        tbl.push_back('{1'b0, 3'd1, 32'd40,   32'd0,          32'hFFFF8002,   1'b0});
        tbl.push_back('{1'b0, 3'd5, 32'd40,   32'd0,          32'h00008002,   1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'd36,   32'hA5B6C7D8,   32'd0,          1'b0});
        tbl.push_back('{1'b0, 3'd1, 32'd38,   32'd0,          32'hFFFFA5B6,   1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'd6,    32'd0,          32'd0,          1'b1});
        tbl.push_back('{1'b1, 3'd1, 32'd41,   32'h0000BEEF,   32'd0,          1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'd40,   32'd0,          32'hCAFE8002,   1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'd1024, 32'd0,          32'd0,          1'b1});
        tbl.push_back('{1'b0, 3'd3, 32'd0,    32'd0,          32'd0,          1'b1});
        tbl.push_back('{1'b1, 3'd4, 32'd12,   32'h000000AA,   32'd0,          1'b1});
        tbl.push_back('{1'b1, 3'd2, 32'd1021, 32'h12345678,   32'd0,          1'b1});
        tbl.push_back('{1'b1, 3'd2, 32'd1020, 32'h0BADF00D,   32'd0,          1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'd1020, 32'd0,          32'h0BADF00D,   1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'd1023, 32'd0,          32'h0000000B,   1'b0});
        tbl.push_back('{1'b0, 3'd5, 32'd1022, 32'd0,          32'h00000BAD,   1'b0});

        foreach (tbl[i]) begin
            txn(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, "vec", gd, ge);
            chk($sformatf("vec%0d.rdata", i), gd, tbl[i].exp_d);
            chk($sformatf("vec%0d.err", i), 32'(ge), 32'(tbl[i].exp_e));
        end

        // Backpressure at latency 3
        txn(1, 1'b1, 3'd2, 32'd4, 32'h5A5A1234, 0, "bp_store", gd, ge);
        txn(1, 1'b0, 3'd2, 32'd4, 32'd0, 5, "bp_load", gd, ge);
        chk("bp_load.value", gd, 32'h5A5A1234);

        // Reset while the latency-3 instance is waiting on a load
        saved = model_load(1, 3'd2, 32'd4);
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_funct3[1] = 3'd2;
        req_addr[1]   = 32'd4;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("rst_mid.wait_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_mid.wait_req_ready", 32'(req_ready[1]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.req_ready", 32'(req_ready[1]), 32'd1);
        chk("rst_mid.rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_mid.rsp_rdata", rsp_rdata[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1, 1'b0, 3'd2, 32'd4, 32'd0, 0, "rst_after", gd, ge);
        chk("rst_after.intact", gd, saved);

        for (int t = 0; t < 300; t++) begin
            w = t % 2;
            if ($urandom_range(0, 9) == 0) a = 32'(1016 + $urandom_range(0, 15));
            else a = 32'($urandom_range(0, 63));
            txn(w, 1'($urandom), f3s[$urandom_range(0, 9)], a, $urandom,
                int'($urandom_range(0, 2)), "rand", gd, ge);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/klp32_dmem_responder.md
Name: klp32_dmem_responder

Overview:
- Data-memory responder for the KLP32 core family: serves load/store requests from a core-side initiator over a valid/ready request channel and a valid/ready response channel.
- Implements RV32I access widths from funct3: sb/sh/sw, lb/lh/lw/lbu/lhu. Includes sign/zero extension, byte-lane steering, a programmable response latency and error signalling for misaligned or out-of-range accesses.
- Replaces the combinational data memory when the core moves to a multi-cycle memory interface.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
req_addr  input  32  byte address.
req_wdata  input  32  store data; low byte or low half is used for sb/sh.
rsp_valid  output  1  response present.
rsp_ready  input  1  initiator accepts the response.
rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
rsp_err  output  1  access was misaligned, out of range, or used an illegal funct3.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Memory contents are not cleared.
  - A reset mid-transaction discards the transaction. A store already committed stays committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A handshake (req_valid & req_ready at the edge) accepts the request and loads the counter with LATENCY-1. Next state is RESP if LATENCY=1, otherwise WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle; go to RESP when it reaches 0.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready at an edge, then return to IDLE.
- Throughput and timing:
  - No back-to-back acceptance: one transaction completes before req_ready rises again.
  - Minimum period is LATENCY+1 cycles when rsp_ready is held high.
  - req_* signals are sampled only at the acceptance edge; later changes on them are ignored.
- Error checks (evaluated at acceptance):
  - funct3 in {001,101} with addr[0]=1 is an error.
  - funct3=010 with addr[1:0]≠00 is an error.
  - Any funct3 not in {000,001,010,100,101} is an error.
  - req_we=1 with funct3 ∈ {100,101} is an error.
  - addr ≥ 4*DEPTH_WORDS is an error.
  - On error: no memory write, rsp_err=1, rsp_rdata=0.
- Stores:
  - Committed at the acceptance edge with a byte-enable write, word index = addr[31:2].
  - sb writes lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes all 4 lanes.
  - Response: rsp_rdata=0, rsp_err=0.
- Loads:
  - The word is read at the acceptance edge and the selected lane(s) are captured into the response register.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw is unmodified.
  - Read-after-write: a load accepted after a store's response completes returns the stored data. Overlapping in-flight accesses cannot occur.
- Counter: 4 bits; never wraps because LATENCY ≤ 15.

Test Plan:
1. Reset with LATENCY=1: req_ready=1, rsp_valid=0, rsp_err=0. Then sw addr 8 wdata 2 -> rsp_valid 1 cycle after acceptance, rdata 0, err 0. Then lw addr 8 -> rdata 0x00000002.
2. sw addr 8 data 0x11223344; sb addr 9 data 0x000000F2; lb addr 9 -> 0xFFFFFFF2; lbu addr 9 -> 0x000000F2; lw addr 8 -> 0x1122F244.
3. sh addr 40 data 0x00008002; lh addr 40 -> 0xFFFF8002; lhu addr 40 -> 0x00008002; lh addr 38 -> err 0 and the upper halfword of word 9.
4. Errors:
   - lw addr 6 -> err 1, rdata 0.
   - sh addr 41 -> err 1, and a later lw addr 40 is unchanged.
   - lw addr 1024 (DEPTH_WORDS=256) -> err 1.
   - funct3=011 -> err 1.
5. Backpressure with LATENCY=3: accept at edge N -> rsp_valid at N+3. Hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stay stable and req_ready=0 throughout. Raise rsp_ready -> next cycle state is IDLE and req_ready=1.
6. Assert reset in WAIT after accepting lw -> rsp_valid=0 and req_ready=1 immediately (asynchronous). Deassert, then lw the same address -> previously stored data is intact.
